// File: rtl/aes_round_ctrl_if.sv
// Signal bundle between the AES round controller and its environment:
// round-counter strobes/feedback, datapath and key-expander controls, and
// the result valid/ready handshake.
interface aes_round_ctrl_if;
  localparam int unsigned RW = 5;

  // Request side
  logic          start;
  logic [1:0]    mode;
  logic          enc;
  logic          key_new;

  // Round counter
  logic [RW-1:0] round_in;
  logic          round_last_in;
  logic          init;
  logic          set;
  logic          enable;
  logic          done;

  // Datapath / key expander
  logic          busy;
  logic          dp_load;
  logic          key_step;
  logic          final_round;
  logic [RW-1:0] key_idx;

  // Result handshake and status
  logic          out_valid;
  logic          out_ready;
  logic          err;

  // Controller side
  modport master (
    input  start, mode, enc, key_new, round_in, round_last_in, out_ready,
    output init, set, enable, done, busy, dp_load, key_step, final_round,
           key_idx, out_valid, err
  );

  // Environment side (counter, datapath, requester, consumer)
  modport slave (
    output start, mode, enc, key_new, round_in, round_last_in, out_ready,
    input  init, set, enable, done, busy, dp_load, key_step, final_round,
           key_idx, out_valid, err
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round-sequencing controller. Steps the external round counter,
// drives datapath/key-expander controls and presents the finished block on
// a valid/ready handshake. Decryption first runs a forward key-expansion
// pass unless the cached schedule is still valid for the requested mode.
module aes_round_ctrl (
  input logic              clk,
  input logic              rst_n,
  aes_round_ctrl_if.master bus
);
  localparam int unsigned RW = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEXP  = 3'd1;
  localparam logic [2:0] S_KCLR  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nx;

  logic [1:0]    mode_q;
  logic          enc_q;
  logic [RW-1:0] nr_q;
  logic [RW-1:0] nr_in;
  logic          dkey_ok;
  logic [1:0]    dkey_mode;
  logic          out_first;
  logic          err_q;

  logic          accept;
  logic          cache_hit;

  logic          init_c;
  logic          set_c;
  logic          enable_c;
  logic          done_c;
  logic          dp_load_c;
  logic          key_step_c;
  logic          final_round_c;
  logic          out_valid_c;
  logic [RW-1:0] key_idx_c;
  logic          err_set_c;

  assign accept    = (state == S_IDLE) && bus.start;
  // A key_new in the same cycle as start already counts as invalidating.
  assign cache_hit = dkey_ok && !bus.key_new && (dkey_mode == bus.mode);

  // Round count for the requested key size
  always_comb begin
    nr_in = RW'(10);
    case (bus.mode)
      2'd2:    nr_in = RW'(12);
      2'd3:    nr_in = RW'(14);
      default: nr_in = RW'(10);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and strobe decode from state and counter feedback
  always_comb begin
    state_nx      = state;
    init_c        = 1'b0;
    set_c         = 1'b0;
    enable_c      = 1'b0;
    done_c        = 1'b0;
    dp_load_c     = 1'b0;
    key_step_c    = 1'b0;
    final_round_c = 1'b0;
    out_valid_c   = 1'b0;
    key_idx_c     = '0;
    err_set_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.enc || cache_hit) state_nx = S_LOAD;
          else                      state_nx = S_KEXP;
        end
      end
      S_KEXP: begin
        set_c      = 1'b1;
        key_step_c = 1'b1;
        if (bus.round_in == RW'(nr_q - RW'(1))) state_nx = S_KCLR;
      end
      S_KCLR: begin
        done_c   = 1'b1;
        state_nx = S_LOAD;
      end
      S_LOAD: begin
        init_c    = 1'b1;
        dp_load_c = 1'b1;
        key_idx_c = enc_q ? '0 : nr_q;
        if (bus.round_in != '0) err_set_c = 1'b1;
        state_nx  = S_ROUND;
      end
      S_ROUND: begin
        key_idx_c = enc_q ? bus.round_in : RW'(nr_q - bus.round_in);
        if (bus.round_in < nr_q) begin
          enable_c = 1'b1;
        end else begin
          final_round_c = 1'b1;
          state_nx      = S_OUT;
        end
      end
      S_OUT: begin
        out_valid_c = 1'b1;
        if (out_first && !bus.round_last_in) err_set_c = 1'b1;
        if (bus.out_ready) begin
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operation parameters captured when a request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      enc_q  <= 1'b0;
      nr_q   <= '0;
    end else if (accept) begin
      mode_q <= bus.mode;
      enc_q  <= bus.enc;
      nr_q   <= nr_in;
    end
  end

  // Decrypt schedule cache; a new key always wins over a completing expansion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dkey_ok   <= 1'b0;
      dkey_mode <= '0;
    end else if (bus.key_new) begin
      dkey_ok   <= 1'b0;
    end else if (state == S_KCLR) begin
      dkey_ok   <= 1'b1;
      dkey_mode <= mode_q;
    end
  end

  // Marks the first cycle spent in OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_first <= 1'b0;
    else        out_first <= (state_nx == S_OUT) && (state != S_OUT);
  end

  // Sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (err_set_c) err_q <= 1'b1;
  end

  assign bus.init        = init_c;
  assign bus.set         = set_c;
  assign bus.enable      = enable_c;
  assign bus.done        = done_c;
  assign bus.busy        = (state != S_IDLE);
  assign bus.dp_load     = dp_load_c;
  assign bus.key_step    = key_step_c;
  assign bus.final_round = final_round_c;
  assign bus.key_idx     = key_idx_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: a behavioural round counter closes
// the loop, the driver pushes per-cycle expected strobe vectors and result
// records, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  aes_round_ctrl_if bus();

  aes_round_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       init;
    logic       set;
    logic       enable;
    logic       done;
    logic       busy;
    logic       dp_load;
    logic       key_step;
    logic       final_round;
    logic       out_valid;
    logic [4:0] key_idx;
  } trace_t;

  typedef struct {
    int   vcyc;
    logic err;
  } result_t;

  trace_t  exp_q[$];
  result_t res_q[$];
  int      n_chk  = 0;
  int      n_fail = 0;
  int      cyc    = 0;
  bit      sb_en  = 1'b0;
  bit      force_rl0 = 1'b0;
  logic [4:0] tb_nr = 5'd10;
  logic [4:0] cnt_round;
  logic       cnt_last;
  trace_t     act;

  assign act = {bus.init, bus.set, bus.enable, bus.done, bus.busy, bus.dp_load,
                bus.key_step, bus.final_round, bus.out_valid, bus.key_idx};

  always @(posedge clk) cyc <= cyc + 1;

  // Round counter model: init/set/enable increment, done clears
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_round <= '0;
      cnt_last  <= 1'b0;
    end else begin
      if (bus.done) cnt_round <= '0;
      else if (bus.init || bus.set || bus.enable) cnt_round <= cnt_round + 5'd1;
      cnt_last <= (cnt_round == tb_nr);
    end
  end
  assign bus.round_in      = cnt_round;
  assign bus.round_last_in = cnt_last & ~force_rl0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, want);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  function automatic int nr_of(input logic [1:0] m);
    case (m)
      2'd2:    return 12;
      2'd3:    return 14;
      default: return 10;
    endcase
  endfunction

  // Expected per-cycle controls from LOAD/KEXP through the OUT handshake
  task automatic push_exp(input logic [1:0] m, input logic e, input bit kexp,
                          input int stall, input int c0, input logic exp_err);
    int      n;
    trace_t  t;
    result_t r;
    n = nr_of(m);
    if (kexp) begin
      for (int i = 1; i <= n; i++) begin
        t = '0; t.busy = 1'b1; t.set = 1'b1; t.key_step = 1'b1;
        exp_q.push_back(t);
      end
      t = '0; t.busy = 1'b1; t.done = 1'b1;
      exp_q.push_back(t);
    end
    t = '0; t.busy = 1'b1; t.init = 1'b1; t.dp_load = 1'b1;
    t.key_idx = e ? 5'd0 : 5'(n);
    exp_q.push_back(t);
    for (int rr = 1; rr <= n; rr++) begin
      t = '0; t.busy = 1'b1;
      t.key_idx = e ? 5'(rr) : 5'(n - rr);
      if (rr < n) t.enable = 1'b1;
      else        t.final_round = 1'b1;
      exp_q.push_back(t);
    end
    for (int s = 0; s < stall; s++) begin
      t = '0; t.busy = 1'b1; t.out_valid = 1'b1;
      exp_q.push_back(t);
    end
    t = '0; t.busy = 1'b1; t.out_valid = 1'b1; t.done = 1'b1;
    exp_q.push_back(t);
    r.vcyc = c0 + (kexp ? (2 * n + 3) : (n + 2));
    r.err  = exp_err;
    res_q.push_back(r);
  endtask

  // Issue one block operation and run it to its handshake.
  // Entered and left at posedge+1; the entry cycle is cycle 0.
  task automatic run_op(input logic [1:0] m, input logic e, input bit kexp,
                        input int stall, input int kn_cyc, input bit disturb,
                        input logic exp_err);
    int vcnt;
    bit hs;
    tb_nr = 5'(nr_of(m));
    push_exp(m, e, kexp, stall, cyc, exp_err);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.enc       = e;
    bus.out_ready = (stall == 0);
    vcnt = 0;
    hs   = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      hs = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      if (hs) break;
      bus.start = disturb && (c == 3 || c == 4);
      if (disturb && c == 3) begin
        bus.mode = ~m;
        bus.enc  = ~e;
      end
      bus.key_new = (c == kn_cyc);
      if (bus.out_valid) vcnt++;
      if (stall > 0) bus.out_ready = (vcnt > stall);
    end
    bus.start     = 1'b0;
    bus.key_new   = 1'b0;
    bus.out_ready = 1'b1;
    if (!hs) begin
      n_chk++;
      n_fail++;
      $display("FAIL op_timeout at cycle %0d: no handshake within 200 cycles", cyc);
      finish_test();
    end
  endtask

  // Monitor: pops expected vectors while busy, checks result timing and err
  initial begin
    trace_t  e;
    result_t r;
    bit      ov_prev  = 1'b0;
    bit      err_pend = 1'b0;
    logic    err_want = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_en && rst_n) begin
        if (err_pend) begin
          chk("err_after_op", 32'(bus.err), 32'(err_want));
          err_pend = 1'b0;
        end
        if (bus.busy) begin
          if (exp_q.size() == 0) begin
            chk("trace_unexpected_busy", 32'(act), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk("trace", 32'(act), 32'(e));
          end
        end else begin
          chk("idle_outputs", 32'(act), 32'(0));
        end
        if (bus.out_valid && !ov_prev) begin
          if (res_q.size() == 0) chk("valid_unexpected", 32'(cyc), 32'(0));
          else                   chk("valid_cycle", 32'(cyc), 32'(res_q[0].vcyc));
        end
        if (bus.out_valid && bus.out_ready && res_q.size() > 0) begin
          r        = res_q.pop_front();
          err_pend = 1'b1;
          err_want = r.err;
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  initial begin
    bus.start     = 1'b0;
    bus.mode      = 2'd0;
    bus.enc       = 1'b1;
    bus.key_new   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(act), 32'(0));
    chk("reset_err", 32'(bus.err), 32'(0));
    rst_n = 1'b1;
    sb_en = 1'b1;
    @(posedge clk); #1;

    // Encrypt AES128, with start/mode/enc disturbed mid-operation
    run_op(2'd0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // New key, then decrypt AES256 with full expansion
    bus.key_new = 1'b1;
    @(posedge clk); #1;
    bus.key_new = 1'b0;
    run_op(2'd3, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    // Back-to-back cached decrypt AES256
    run_op(2'd3, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // AES192 after an AES256 cache: mode mismatch forces expansion
    run_op(2'd2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    // Cached AES192 with key_new mid-round: block completes unchanged
    run_op(2'd2, 1'b0, 1'b0, 0, 5, 1'b0, 1'b0);
    // Cache now invalid; key_new lands on KCLR (cycle 13) and must win
    run_op(2'd2, 1'b0, 1'b1, 0, 13, 1'b0, 1'b0);
    run_op(2'd2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    // AES192 cached, AES128 requested: expansion runs, valid at 23
    run_op(2'd1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    // Encrypt AES192 with five cycles of backpressure
    run_op(2'd2, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0);
    // Cached AES128 decrypt
    run_op(2'd1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // round_last missing in OUT raises a sticky err
    force_rl0 = 1'b1;
    run_op(2'd0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    force_rl0 = 1'b0;
    run_op(2'd3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of a cached AES128 decrypt
    sb_en     = 1'b0;
    tb_nr     = 5'd10;
    bus.start = 1'b1;
    bus.mode  = 2'd1;
    bus.enc   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_mid_round", 32'(bus.busy), 32'(1));
    chk("enable_mid_round", 32'(bus.enable), 32'(1));
    chk("err_before_reset", 32'(bus.err), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(act), 32'(0));
    chk("async_reset_err", 32'(bus.err), 32'(0));
    @(posedge clk); #1;
    chk("held_reset_outputs", 32'(act), 32'(0));
    rst_n = 1'b1;
    exp_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    sb_en = 1'b1;
    @(posedge clk); #1;

    // Cache was dropped by reset: decrypt must expand again
    run_op(2'd1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("trace_queue_drained", 32'(exp_q.size()), 32'(0));
    chk("result_queue_drained", 32'(res_q.size()), 32'(0));
    finish_test();
  end
endmodule
